// File: rtl/input_debounce_sync_pkg.sv
// Shared constants, limits and helpers for the input debounce/synchroniser block.
package input_pkg;

  // 10 ms of stability at a 25 MHz clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

  // Legal synchroniser depths per channel.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Per-cycle event decoded by a channel before it is registered onto rise/fall.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RISE = 2'd1,
    EV_FALL = 2'd2
  } edge_e;

  // Counter width able to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : input_pkg

// File: rtl/input_debounce_sync_if.sv
// Pin-side and debounced-side signals of the debounce block, bundled for port use.
interface input_debounce_sync_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] din;
  logic             bypass;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_rise;

  // Driver of the raw pins and consumer of the debounced levels.
  modport master (
    output din,
    output bypass,
    input  q,
    input  rise,
    input  fall,
    input  any_rise
  );

  // The debounce block itself.
  modport slave (
    input  din,
    input  bypass,
    output q,
    output rise,
    output fall,
    output any_rise
  );

endinterface : input_debounce_sync_if

// File: rtl/input_debounce_sync_channel.sv
// One channel: optional inversion, synchroniser chain, stability counter and edge pulses.
module debounce_channel
  import input_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic INVERT          = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic bypass,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [SYNC_STAGES-1:0] sync_ff;

  logic          synced;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          q_next;
  edge_e         ev;

  assign synced = sync_ff[SYNC_STAGES-1];

  // Shift the (possibly inverted) pin through the metastability chain.
  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], din ^ INVERT};
  end

  // Decide whether the synced level is accepted this edge or keeps counting.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_next = '0;
    q_next   = q;
    ev       = EV_NONE;
    if (synced != q) begin
      if (bypass || cnt == LAST) begin
        q_next = ~q;
        ev     = q ? EV_FALL : EV_RISE;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Register the debounced level, counter and one-cycle edge pulses together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= q_next;
      cnt  <= cnt_next;
      rise <= (ev == EV_RISE);
      fall <= (ev == EV_FALL);
    end
  end

endmodule : debounce_channel

// File: rtl/input_debounce_sync.sv
// Top level: WIDTH independent debounce channels plus the any_rise summary.
module input_debounce_sync
  import input_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input_debounce_sync_if.slave bus
);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .din    (bus.din[i]),
      .bypass (bus.bypass),
      .q      (q_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  assign bus.q    = q_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;
  // OR of registered pulses: aligned with rise and still free of any din path.
  assign bus.any_rise = |rise_w;

endmodule : input_debounce_sync

// File: tb/tb_input_debounce_sync.sv
// Directed scenarios followed by random pin activity, checked against a window model.
module tb_input_debounce_sync;

  localparam int         W    = 4;
  localparam int         S    = 2;
  localparam int         D    = 8;
  localparam logic [3:0] INV  = 4'b1111;
  localparam int         MAXE = 8192;

  logic clk = 1'b0;
  logic reset;

  input_debounce_sync_if #(.WIDTH(W)) bus ();

  input_debounce_sync #(
    .WIDTH           (W),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .INVERT_MASK     (INV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: logical pin value sampled at each post-reset edge, and the
  // rule "q flips once the last N seen values since the previous flip all differ
  // from q", with N = 1 under bypass and D otherwise. The debouncer at edge e
  // sees the pin sampled at edge e-S (zero while the chain is still refilling).
  bit       h [W][MAXE];
  int       n_edge;
  int       last_chg [W];
  bit [W-1:0] mq, mrise, mfall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit seen(input int ch, input int e);
    return (e - S >= 1) ? h[ch][e-S] : 1'b0;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    mq     = '0;
    mrise  = '0;
    mfall  = '0;
    for (int c = 0; c < W; c++) last_chg[c] = 0;
  endtask

  task automatic model_edge();
    int  need;
    bit  tog;
    n_edge++;
    if (n_edge >= MAXE) $fatal(1, "FAIL model_history: edge budget %0d exceeded", MAXE);
    need = bus.bypass ? 1 : D;
    for (int c = 0; c < W; c++) begin
      h[c][n_edge] = bus.din[c] ^ INV[c];
      tog = 1'b1;
      for (int k = 0; k < need; k++) begin
        if (n_edge - k <= last_chg[c] || seen(c, n_edge - k) == mq[c]) tog = 1'b0;
      end
      mrise[c] = tog && !mq[c];
      mfall[c] = tog && mq[c];
      if (tog) begin
        mq[c]       = ~mq[c];
        last_chg[c] = n_edge;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"},        bus.q,        mq);
    check({tag, "_rise"},     bus.rise,     mrise);
    check({tag, "_fall"},     bus.fall,     mfall);
    check({tag, "_any_rise"}, bus.any_rise, |mrise);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"},        bus.q,        '0);
    check({tag, "_rise"},     bus.rise,     '0);
    check({tag, "_fall"},     bus.fall,     '0);
    check({tag, "_any_rise"}, bus.any_rise, '0);
  endtask

  // One clock edge: advance the model on the pre-edge inputs, check 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset between edges, held for some edges, released mid-cycle.
  task automatic reset_pulse(input int hold);
    #3 reset = 1'b1;
    #1 check_zero("rst_async");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check_zero("rst_hold");
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  int         hold_cnt [W];
  int         byp_cnt;
  logic [3:0] act;

  initial begin
    reset      = 1'b0;
    bus.din    = 4'hF;
    bus.bypass = 1'b0;
    model_reset();

    // Reset with all pins at their idle level: nothing moves.
    #2 reset = 1'b1;
    #1 check_zero("r30_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_zero("r30_hold");
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) step("r30_idle");
    check("r30_q_after", bus.q, 4'h0);

    // Channel 0 goes active: exactly S+D edges to q and a single rise.
    bus.din[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("r31");
      if (i < 10) check("r31_q0_wait", bus.q[0], 1'b0);
    end
    check("r31_q0", bus.q[0], 1'b1);
    check("r31_rise0", bus.rise[0], 1'b1);
    check("r31_any_rise", bus.any_rise, 1'b1);
    step("r31_after");
    check("r31_rise0_once", bus.rise[0], 1'b0);

    // Glitch of D-1 cycles on channel 1 is rejected.
    act = '0;
    bus.din[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step("r32");
      act[0] = act[0] | bus.q[1] | bus.rise[1] | bus.fall[1];
    end
    bus.din[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step("r32");
      act[0] = act[0] | bus.q[1] | bus.rise[1] | bus.fall[1];
    end
    check("r32_no_activity", act[0], 1'b0);

    // Two channels change together and report together.
    bus.din[3:2] = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      step("r33a");
      if (i == 9)  check("r33_rise_early", bus.rise[3:2], 2'b00);
      if (i == 10) check("r33_rise", bus.rise[3:2], 2'b11);
    end
    bus.din[3:2] = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      step("r33b");
      if (i == 9) check("r33_fall_early", bus.fall[3:2], 2'b00);
    end
    check("r33_fall", bus.fall[3:2], 2'b11);

    // Bypass: S+1 edges; then bypass raised with the count at 4.
    bus.bypass = 1'b1;
    bus.din[0] = 1'b1;
    step("r34a");
    step("r34a");
    check("r34_q0_wait", bus.q[0], 1'b1);
    step("r34a");
    check("r34_q0_bypass", bus.q[0], 1'b0);
    check("r34_fall0", bus.fall[0], 1'b1);
    bus.bypass = 1'b0;
    bus.din[0] = 1'b0;
    for (int i = 0; i < 6; i++) step("r34b");
    check("r34_q0_counting", bus.q[0], 1'b0);
    bus.bypass = 1'b1;
    step("r34c");
    check("r34_q0_midcount", bus.q[0], 1'b1);
    check("r34_rise0_midcount", bus.rise[0], 1'b1);
    bus.bypass = 1'b0;

    // Reset 5 cycles into a change on channel 1: full latency again after release.
    bus.din[1] = 1'b0;
    for (int i = 0; i < 5; i++) step("r35a");
    reset_pulse(2);
    for (int i = 1; i <= 10; i++) begin
      step("r35b");
      if (i < 10) check("r35_quiet", {bus.rise[1], bus.fall[1]}, 2'b00);
    end
    check("r35_q1", bus.q[1], 1'b1);
    check("r35_rise1", bus.rise[1], 1'b1);

    // Random pin activity, occasional bypass windows and resets.
    for (int c = 0; c < W; c++) hold_cnt[c] = 0;
    byp_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < W; c++) begin
        if (hold_cnt[c] == 0) begin
          bus.din[c]  = 1'($urandom_range(0, 1));
          hold_cnt[c] = int'($urandom_range(1, 14));
        end else begin
          hold_cnt[c]--;
        end
      end
      if (byp_cnt > 0) begin
        byp_cnt--;
        if (byp_cnt == 0) bus.bypass = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.bypass = 1'b1;
        byp_cnt    = int'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 499) == 0) reset_pulse(int'($urandom_range(1, 3)));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_input_debounce_sync
